// File: rtl/ring_renderer_pkg.sv
// rtl/ring_renderer_pkg.sv - shared symbols for ring_renderer: screen size, radius FSM states, colour codes
package ring_renderer_pkg;

  localparam int HRES = 640;
  localparam int VRES = 480;

  typedef enum logic [1:0] {
    RS_GROW     = 2'd0,
    RS_HOLD_MAX = 2'd1,
    RS_SHRINK   = 2'd2,
    RS_HOLD_MIN = 2'd3
  } rs_state_t;

  localparam logic [1:0] SEL_WHITE = 2'b00;
  localparam logic [1:0] SEL_RED   = 2'b01;
  localparam logic [1:0] SEL_GREEN = 2'b10;
  localparam logic [1:0] SEL_BLUE  = 2'b11;

  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_WHITE = 3'b111;
  localparam logic [2:0] RGB_RED   = 3'b100;
  localparam logic [2:0] RGB_GREEN = 3'b010;
  localparam logic [2:0] RGB_BLUE  = 3'b001;

  function automatic logic [2:0] sel_to_rgb(input logic [1:0] sel);
    logic [2:0] rgb;
    case (sel)
      SEL_RED:   rgb = RGB_RED;
      SEL_GREEN: rgb = RGB_GREEN;
      SEL_BLUE:  rgb = RGB_BLUE;
      default:   rgb = RGB_WHITE;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/ring_renderer_dist_sq.sv
// rtl/ring_renderer_dist_sq.sv - squared distance from ring centre with matched blank delay (border line under RING_BORDER_EN)
module dist_sq
  import ring_renderer_pkg::*;
#(
  parameter int CX = 320,
  parameter int CY = 240
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic        blank,
`ifdef RING_BORDER_EN
  output logic        border_d,
`endif
  output logic [24:0] sum,
  output logic        blank_d
);

  logic signed [12:0] dx, dy;
  logic [11:0]        adx, ady;
  logic [23:0]        dx2, dy2;
  logic               blank1, blank2;

  // Offsets never exceed 12 bits of magnitude, so square the absolute value unsigned.
  assign adx = 12'(dx[12] ? -dx : dx);
  assign ady = 12'(dy[12] ? -dy : dy);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dx     <= '0;
      dy     <= '0;
      dx2    <= '0;
      dy2    <= '0;
      blank1 <= 1'b1;
      blank2 <= 1'b1;
    end else begin
      dx     <= {1'b0, x} - 13'(CX);
      dy     <= {1'b0, y} - 13'(CY);
      dx2    <= 24'(adx) * 24'(adx);
      dy2    <= 24'(ady) * 24'(ady);
      blank1 <= blank;
      blank2 <= blank1;
    end
  end

  assign sum     = 25'(dx2) + 25'(dy2);
  assign blank_d = blank2;

`ifdef RING_BORDER_EN
  logic border1, border2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      border1 <= 1'b0;
      border2 <= 1'b0;
    end else begin
      border1 <= (x == 12'd0) || (x == 12'(HRES - 1)) ||
                 (y == 12'd0) || (y == 12'(VRES - 1));
      border2 <= border1;
    end
  end

  assign border_d = border2;
`endif

endmodule

// File: rtl/ring_renderer.sv
// rtl/ring_renderer.sv - animated breathing ring pixel stage; RING_BORDER_EN adds a white screen border
module ring_renderer
  import ring_renderer_pkg::*;
#(
  parameter int CX          = 320,
  parameter int CY          = 240,
  parameter int R_MIN       = 20,
  parameter int R_MAX       = 200,
  parameter int R_STEP      = 2,
  parameter int BAND        = 10,
  parameter int HOLD_FRAMES = 30
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic        i_hblank,
  input  logic        i_vblank,
  input  logic [1:0]  i_sel,
  output logic        o_red,
  output logic        o_grn,
  output logic        o_blu,
  output logic        o_blank,
  output logic [9:0]  o_radius
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  logic               vblank_q;
  logic               frame_strobe;
  rs_state_t          state;
  logic [9:0]         radius, rad_next;
  logic [HW-1:0]      hold_cnt;
  logic [19:0]        r_sq;
  logic [1:0]         col;
  logic               grow_done, shrink_done;
  logic [24:0]        sum;
  logic               blank_d;
  logic signed [25:0] sum_s, lo, hi;
  logic               hit;
  logic [2:0]         rgb_q;
`ifdef RING_BORDER_EN
  logic               border_d;
`endif

  dist_sq #(.CX(CX), .CY(CY)) u_dist_sq (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .x       (i_x),
    .y       (i_y),
    .blank   (i_hblank | i_vblank),
`ifdef RING_BORDER_EN
    .border_d(border_d),
`endif
    .sum     (sum),
    .blank_d (blank_d)
  );

  assign frame_strobe = i_vblank & ~vblank_q;
  assign grow_done    = ({1'b0, radius} + 11'(R_STEP)) >= 11'(R_MAX);
  assign shrink_done  = {1'b0, radius} <= 11'(R_MIN + R_STEP);

  always_comb begin
    rad_next = radius;
    case (state)
      RS_GROW:   rad_next = grow_done   ? 10'(R_MAX) : radius + 10'(R_STEP);
      RS_SHRINK: rad_next = shrink_done ? 10'(R_MIN) : radius - 10'(R_STEP);
      default:   rad_next = radius;
    endcase
  end

  // r_sq tracks the radius that will be displayed, so the ring always matches o_radius.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vblank_q <= 1'b1;
      state    <= RS_GROW;
      radius   <= 10'(R_MIN);
      hold_cnt <= '0;
      r_sq     <= 20'(R_MIN * R_MIN);
      col      <= SEL_WHITE;
    end else begin
      vblank_q <= i_vblank;
      if (frame_strobe) begin
        radius <= rad_next;
        r_sq   <= 20'(rad_next) * 20'(rad_next);
        col    <= i_sel;
        case (state)
          RS_GROW:
            if (grow_done) begin
              hold_cnt <= '0;
              state    <= RS_HOLD_MAX;
            end
          RS_HOLD_MAX: begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HW'(HOLD_FRAMES - 1)) state <= RS_SHRINK;
          end
          RS_SHRINK:
            if (shrink_done) begin
              hold_cnt <= '0;
              state    <= RS_HOLD_MIN;
            end
          RS_HOLD_MIN: begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HW'(HOLD_FRAMES - 1)) state <= RS_GROW;
          end
          default: state <= RS_GROW;
        endcase
      end
    end
  end

  // Signed bounds keep a small r_sq from wrapping the lower edge of the band.
  assign sum_s = $signed({1'b0, sum});
  assign lo    = $signed({6'b0, r_sq}) - $signed(26'(BAND));
  assign hi    = $signed({6'b0, r_sq}) + $signed(26'(BAND));
  assign hit   = (sum_s > lo) && (sum_s < hi);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_q   <= RGB_OFF;
      o_blank <= 1'b1;
    end else begin
      o_blank <= blank_d;
      if (blank_d)
        rgb_q <= RGB_OFF;
`ifdef RING_BORDER_EN
      else if (border_d)
        rgb_q <= RGB_WHITE;
`endif
      else if (hit)
        rgb_q <= sel_to_rgb(col);
      else
        rgb_q <= RGB_OFF;
    end
  end

  assign o_red    = rgb_q[2];
  assign o_grn    = rgb_q[1];
  assign o_blu    = rgb_q[0];
  assign o_radius = radius;

endmodule

// File: tb/tb_ring_renderer.sv
// tb/tb_ring_renderer.sv - self-checking bench for ring_renderer (default and fixed-radius instances; honours RING_BORDER_EN)
module tb_ring_renderer;
  import ring_renderer_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [11:0] i_x = '0;
  logic [11:0] i_y = '0;
  logic        i_hblank = 1'b0;
  logic        i_vblank = 1'b0;
  logic [1:0]  i_sel = 2'b00;

  logic       d_red, d_grn, d_blu, d_blank;
  logic [9:0] d_radius;
  logic       f_red, f_grn, f_blu, f_blank;
  logic [9:0] f_radius;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  ring_renderer u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y),
    .i_hblank(i_hblank), .i_vblank(i_vblank), .i_sel(i_sel),
    .o_red(d_red), .o_grn(d_grn), .o_blu(d_blu), .o_blank(d_blank), .o_radius(d_radius)
  );

  ring_renderer #(.R_MIN(100), .R_MAX(100)) u_fix (
    .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y),
    .i_hblank(i_hblank), .i_vblank(i_vblank), .i_sel(i_sel),
    .o_red(f_red), .o_grn(f_grn), .o_blu(f_blu), .o_blank(f_blank), .o_radius(f_radius)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Radius after n frame strobes with default parameters: 90 grow, 30 hold, 90 shrink, 30 hold.
  function automatic int rad_model(input int n);
    int m;
    if (n == 0) return 20;
    m = n % 240;
    if (m >= 1 && m <= 90) return (20 + 2 * m > 200) ? 200 : 20 + 2 * m;
    if (m >= 91 && m <= 120) return 200;
    if (m >= 121 && m <= 210) return (200 - 2 * (m - 120) < 20) ? 20 : 200 - 2 * (m - 120);
    return 20;
  endfunction

  function automatic logic [2:0] colour(input int c);
    case (c)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  typedef struct {
    int x;
    int y;
    bit blank;
  } rec_t;

  function automatic logic [2:0] pix(input rec_t r, input int rad, input int c);
    int s, rs;
    if (r.blank) return 3'b000;
`ifdef RING_BORDER_EN
    if (r.x == 0 || r.x == HRES - 1 || r.y == 0 || r.y == VRES - 1) return 3'b111;
`endif
    s  = (r.x - 320) * (r.x - 320) + (r.y - 240) * (r.y - 240);
    rs = rad * rad;
    return (s > rs - 10 && s < rs + 10) ? colour(c) : 3'b000;
  endfunction

  rec_t     hist[$];
  int       nstrobe = 0;
  bit       vq = 1'b1;
  int       col = 0;
  logic [2:0] exp_rgb, exp_frgb;
  bit       exp_blank;
  int       exp_rad = 20;
  bit       model_ok = 1'b0;

  always @(posedge i_clk) begin : model
    rec_t r;
    r.x = i_x;
    r.y = i_y;
    r.blank = i_hblank | i_vblank;
    if (i_rst) begin
      foreach (hist[i]) hist[i].blank = 1'b1;
      r.blank = 1'b1;
    end
    hist.push_back(r);
    while (hist.size() > 3) void'(hist.pop_front());
    if (i_rst) begin
      exp_rgb = 3'b000;
      exp_frgb = 3'b000;
      exp_blank = 1'b1;
    end else begin
      exp_blank = hist[0].blank;
      exp_rgb = pix(hist[0], rad_model(nstrobe), col);
      exp_frgb = pix(hist[0], 100, col);
    end
    if (i_rst) begin
      nstrobe = 0;
      col = 0;
      vq = 1'b1;
    end else begin
      if (i_vblank && !vq) begin
        nstrobe++;
        col = i_sel;
      end
      vq = i_vblank;
    end
    exp_rad = rad_model(nstrobe);
    model_ok = 1'b1;
  end

  always @(negedge i_clk) begin
    if (model_ok) begin
      check("rgb", {d_red, d_grn, d_blu}, exp_rgb);
      check("blank", d_blank, exp_blank);
      check("radius", d_radius, exp_rad);
      check("fix_rgb", {f_red, f_grn, f_blu}, exp_frgb);
      check("fix_blank", f_blank, exp_blank);
      check("fix_radius", f_radius, 100);
    end
  end

  task automatic pix_check(input string nm, input int x, input int y,
                           input logic [2:0] ef, input logic [2:0] ed);
    i_x = 12'(x);
    i_y = 12'(y);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check({nm, "_fix"}, {f_red, f_grn, f_blu}, ef);
    check({nm, "_def"}, {d_red, d_grn, d_blu}, ed);
  endtask

  task automatic strobe();
    @(negedge i_clk) i_vblank = 1'b1;
    @(negedge i_clk) i_vblank = 1'b0;
  endtask

  initial begin
    logic [2:0] bexp;
    int r, dx, dy, k;

    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("reset_rgb", {d_red, d_grn, d_blu}, 0);
      check("reset_blank", d_blank, 1);
      check("reset_radius", d_radius, 20);
    end
    i_rst = 1'b0;

    pix_check("p420_240", 420, 240, 3'b111, 3'b000);
    pix_check("p420_250", 420, 250, 3'b000, 3'b000);
    pix_check("p329_240", 329, 240, 3'b000, 3'b000);
    pix_check("p420_243", 420, 243, 3'b111, 3'b000);
    pix_check("p340_240", 340, 240, 3'b000, 3'b111);
    pix_check("centre", 320, 240, 3'b000, 3'b000);

    @(negedge i_clk);
    i_x = 12'd420;
    i_y = 12'd240;
    @(negedge i_clk) i_hblank = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("hblank_last_hit", {f_red, f_grn, f_blu}, 3'b111);
    check("hblank_last_blank", f_blank, 0);
    @(negedge i_clk);
    check("hblank_masked", {f_red, f_grn, f_blu}, 3'b000);
    check("hblank_masked_blank", f_blank, 1);
    i_hblank = 1'b0;

    i_sel = 2'b10;
    pix_check("sel_before", 420, 240, 3'b111, 3'b000);
    strobe();
    pix_check("sel_after", 420, 240, 3'b010, 3'b000);
    check("radius_1", d_radius, 22);

`ifdef RING_BORDER_EN
    bexp = 3'b111;
`else
    bexp = 3'b000;
`endif
    pix_check("border_left", 0, 100, bexp, bexp);
    pix_check("border_right", HRES - 1, 100, bexp, bexp);

    repeat (9) strobe();
    check("radius_10", d_radius, 40);
    repeat (80) strobe();
    check("radius_90", d_radius, 200);
    strobe();
    check("radius_91", d_radius, 200);
    repeat (29) strobe();
    check("radius_120", d_radius, 200);
    strobe();
    check("radius_121", d_radius, 198);

    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk);
      if (c == 2000) i_rst = 1'b1;
      if (c == 2002) i_rst = 1'b0;
      i_hblank = ($urandom % 10) == 0;
      if (($urandom % 50) == 0) i_vblank = ~i_vblank;
      if (($urandom % 30) == 0) i_sel = 2'($urandom);
      k = $urandom % 4;
      if (k < 3) begin
        r = (k == 0) ? 100 : exp_rad;
        dx = $urandom_range(0, r);
        dy = int'($sqrt(real'(r * r - dx * dx))) + int'($urandom_range(0, 2)) - 1;
        if (dy < 0) dy = 0;
        i_x = 12'(($urandom % 2) ? 320 + dx : 320 - dx);
        i_y = 12'(($urandom % 2) ? 240 + dy : 240 - dy);
      end else begin
        i_x = 12'($urandom_range(0, HRES + 50));
        i_y = 12'($urandom_range(0, VRES + 20));
        if (($urandom % 4) == 0) i_x = 12'(HRES - 1);
      end
    end

    i_vblank = 1'b0;
    i_hblank = 1'b0;
    repeat (4) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
